rsa_job_scheduler: RTL and testbench

RSA_JOB_SCHEDULER -- requirements
Module: rsa_job_scheduler

---
 rtl/rsa_job_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_rsa_job_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_job_scheduler.sv
// rsa_job_scheduler: round-robin arbiter feeding two RSA job requesters into one inverter/mod-exp core,
//   with a single-entry key cache that skips the inverter when p,q match the last inverted pair.
// Latency: grant + INV_GO + inverter wait + EXP_GO + mod-exp wait + 1 to rsp_valid; a cache hit skips INV_GO/INV_WAIT.
// Backpressure: one job in flight; reqN_ready only in IDLE; result held in RESP until rsp_ready.
// Ports: req0_*/req1_* job requests (valid/ready, p, q, dir, msg); rsp_* result (valid/ready, id, err, msg);
//   core_* registered operands and one-cycle start pulses to the core; core_*_finish/core_msg_out back from it.
module rsa_job_scheduler #(
  parameter int WIDTH   = 128,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic               req1_valid,
  output logic               req0_ready,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req0_p,
  input  logic [WIDTH-1:0]   req0_q,
  input  logic [WIDTH-1:0]   req1_p,
  input  logic [WIDTH-1:0]   req1_q,
  input  logic               req0_dir,
  input  logic               req1_dir,
  input  logic [2*WIDTH-1:0] req0_msg,
  input  logic [2*WIDTH-1:0] req1_msg,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic               rsp_err,
  output logic [2*WIDTH-1:0] rsp_msg,
  output logic [WIDTH-1:0]   core_p,
  output logic [WIDTH-1:0]   core_q,
  output logic               core_dir,
  output logic [2*WIDTH-1:0] core_msg,
  output logic               core_reset_inverter,
  output logic               core_reset_mod_exp,
  input  logic               core_inverter_finish,
  input  logic               core_mod_exp_finish,
  input  logic [2*WIDTH-1:0] core_msg_out
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, INV_GO, INV_WAIT, EXP_GO, EXP_WAIT, RESP} state_e;

  state_e               state_q;
  logic                 prio_q;       // requester that wins a tie; flips to the other one on every grant
  logic [WIDTH-1:0]     p_q, q_q;
  logic                 dir_q, id_q;
  logic [2*WIDTH-1:0]   msg_q;
  logic                 cache_vld_q;
  logic [WIDTH-1:0]     cache_p_q, cache_q_q;
  logic [CW-1:0]        cnt_q;
  logic                 rsp_vld_q, rsp_err_q;
  logic [2*WIDTH-1:0]   rsp_msg_q;
  logic                 rst_inv_q, rst_exp_q;

  logic                 grant_vld, grant_id, cache_hit;
  logic                 first_cyc, phase_tmo;
  logic [WIDTH-1:0]     sel_p, sel_q;

  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) grant_id = prio_q;
    else                          grant_id = req1_valid;
  end

  assign grant_vld  = (state_q == IDLE) && (req0_valid || req1_valid);
  // Gated with rst_n so ready reads 0 while reset is held, even with a request pending.
  assign req0_ready = rst_n && grant_vld && !grant_id;
  assign req1_ready = rst_n && grant_vld &&  grant_id;

  assign sel_p     = grant_id ? req1_p : req0_p;
  assign sel_q     = grant_id ? req1_q : req0_q;
  assign cache_hit = cache_vld_q && (sel_p == cache_p_q) && (sel_q == cache_q_q);

  // Counter is 0 only in the first cycle of a WAIT state: a finish still high from the
  // previous job is ignored there.
  assign first_cyc = (cnt_q == '0);
  assign phase_tmo = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      p_q         <= '0;
      q_q         <= '0;
      dir_q       <= 1'b0;
      id_q        <= 1'b0;
      msg_q       <= '0;
      cache_vld_q <= 1'b0;
      cache_p_q   <= '0;
      cache_q_q   <= '0;
      cnt_q       <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_msg_q   <= '0;
      rst_inv_q   <= 1'b0;
      rst_exp_q   <= 1'b0;
    end else begin
      // Start pulses are raised on the transition into a GO state, so they last exactly its one cycle.
      rst_inv_q <= 1'b0;
      rst_exp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            p_q    <= sel_p;
            q_q    <= sel_q;
            dir_q  <= grant_id ? req1_dir : req0_dir;
            msg_q  <= grant_id ? req1_msg : req0_msg;
            id_q   <= grant_id;
            prio_q <= ~grant_id;
            if (cache_hit) begin
              state_q   <= EXP_GO;
              rst_exp_q <= 1'b1;
            end else begin
              state_q   <= INV_GO;
              rst_inv_q <= 1'b1;
            end
          end
        end
        INV_GO: begin
          state_q <= INV_WAIT;
          cnt_q   <= '0;
        end
        INV_WAIT: begin
          if (!first_cyc && core_inverter_finish) begin
            cache_vld_q <= 1'b1;
            cache_p_q   <= p_q;
            cache_q_q   <= q_q;
            state_q     <= EXP_GO;
            rst_exp_q   <= 1'b1;
          end else if (phase_tmo) begin
            cache_vld_q <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_msg_q   <= '0;
            rsp_vld_q   <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        EXP_GO: begin
          state_q <= EXP_WAIT;
          cnt_q   <= '0;
        end
        EXP_WAIT: begin
          if (!first_cyc && core_mod_exp_finish) begin
            rsp_err_q <= 1'b0;
            rsp_msg_q <= core_msg_out;
            rsp_vld_q <= 1'b1;
            state_q   <= RESP;
          end else if (phase_tmo) begin
            cache_vld_q <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_msg_q   <= '0;
            rsp_vld_q   <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_vld_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid           = rsp_vld_q;
  assign rsp_id              = id_q;
  assign rsp_err             = rsp_err_q;
  assign rsp_msg             = rsp_msg_q;
  assign core_p              = p_q;
  assign core_q              = q_q;
  assign core_dir            = dir_q;
  assign core_msg            = msg_q;
  assign core_reset_inverter = rst_inv_q;
  assign core_reset_mod_exp  = rst_exp_q;

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// tb_rsa_job_scheduler: directed bench for rsa_job_scheduler with a behavioural core
//   (inverter done 2 cycles after its pulse is seen, mod-exp done 3 cycles after, result = msg ^ KEY).
module tb_rsa_job_scheduler;
  localparam int W   = 128;
  localparam int MW  = 2 * W;
  localparam logic [MW-1:0] KEY = 256'hc0ffee00_12345678_9abcdef0_0badf00d_deadbeef_5a5a5a5a_a5a5a5a5_01020304;
  localparam logic [W-1:0]  P1  = 128'd113680897410347;
  localparam logic [W-1:0]  Q1  = 128'd7999808077935876437321;
  localparam logic [W-1:0]  P2  = 128'd1000003;
  localparam logic [W-1:0]  Q2  = 128'd998244353;
  localparam logic [W-1:0]  P3  = 128'd65537;
  localparam logic [W-1:0]  Q3  = 128'd2147483647;
  localparam logic [MW-1:0] M1  = 256'h3ab37b2857e7e149;
  localparam logic [MW-1:0] M2  = 256'h1111_2222_3333_4444_5555;
  localparam logic [MW-1:0] M3  = 256'hfeed_face_cafe_beef;
  localparam logic [MW-1:0] M4  = 256'h0a0a_0b0b;
  localparam logic [MW-1:0] M5  = 256'h7777_8888_9999;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0]  req0_p, req0_q, req1_p, req1_q;
  logic          req0_dir, req1_dir;
  logic [MW-1:0] req0_msg, req1_msg;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [MW-1:0] rsp_msg;
  logic [W-1:0]  core_p, core_q;
  logic          core_dir, core_reset_inverter, core_reset_mod_exp;
  logic [MW-1:0] core_msg, core_msg_out;
  logic          core_inverter_finish, core_mod_exp_finish;

  rsa_job_scheduler #(.WIDTH(W), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_p(req0_p), .req0_q(req0_q), .req1_p(req1_p), .req1_q(req1_q),
    .req0_dir(req0_dir), .req1_dir(req1_dir),
    .req0_msg(req0_msg), .req1_msg(req1_msg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .rsp_msg(rsp_msg),
    .core_p(core_p), .core_q(core_q), .core_dir(core_dir), .core_msg(core_msg),
    .core_reset_inverter(core_reset_inverter), .core_reset_mod_exp(core_reset_mod_exp),
    .core_inverter_finish(core_inverter_finish), .core_mod_exp_finish(core_mod_exp_finish),
    .core_msg_out(core_msg_out)
  );

  // Behavioural core. inv_force holds the inverter finish high (stale level);
  // exp_stuck masks the mod-exp finish so the phase times out.
  logic [3:0] inv_cnt, exp_cnt;
  logic       inv_done, exp_done;
  logic       inv_force = 1'b0;
  logic       exp_stuck = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_cnt  <= 4'd0;
      exp_cnt  <= 4'd0;
      inv_done <= 1'b0;
      exp_done <= 1'b0;
    end else begin
      if (core_reset_inverter) begin
        inv_cnt  <= 4'd2;
        inv_done <= 1'b0;
      end else if (inv_cnt != 4'd0) begin
        inv_cnt  <= inv_cnt - 4'd1;
        inv_done <= (inv_cnt == 4'd1);
      end
      if (core_reset_mod_exp) begin
        exp_cnt  <= 4'd3;
        exp_done <= 1'b0;
      end else if (exp_cnt != 4'd0) begin
        exp_cnt  <= exp_cnt - 4'd1;
        exp_done <= (exp_cnt == 4'd1);
      end
    end
  end

  assign core_inverter_finish = inv_done | inv_force;
  assign core_mod_exp_finish  = exp_done & ~exp_stuck;
  assign core_msg_out         = core_msg ^ KEY;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Per-job observations; cycle 0 is the grant cycle.
  int            j_lat, j_inv, j_exp, j_inv_at, j_exp_at;
  logic          j_id, j_err;
  logic [MW-1:0] j_msg;

  task automatic run_job(input bit idx, input logic [W-1:0] p, input logic [W-1:0] q, input bit dir,
                         input logic [MW-1:0] msg, input int hold, input string tag);
    bit got;
    int cyc;
    j_inv = 0; j_exp = 0; j_inv_at = -1; j_exp_at = -1; j_lat = -1;
    j_id = 1'b0; j_err = 1'b0; j_msg = '0;
    step();
    rsp_ready = (hold == 0);
    if (idx) begin
      req1_p = p; req1_q = q; req1_dir = dir; req1_msg = msg; req1_valid = 1'b1;
    end else begin
      req0_p = p; req0_q = q; req0_dir = dir; req0_msg = msg; req0_valid = 1'b1;
    end
    #1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (idx ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check({tag, "_grant"}, MW'(got), MW'(1));
    step();
    cyc = 1;
    check({tag, "_rdy_busy"}, MW'(idx ? req1_ready : req0_ready), MW'(0));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (core_reset_inverter) begin j_inv++; if (j_inv_at < 0) j_inv_at = cyc; end
      if (core_reset_mod_exp)  begin j_exp++; if (j_exp_at < 0) j_exp_at = cyc; end
      if (rsp_valid) begin j_lat = cyc; break; end
      step();
      cyc++;
    end
    if (j_lat >= 0) begin
      j_id = rsp_id; j_err = rsp_err; j_msg = rsp_msg;
      for (int h = 0; h < hold; h++) begin
        step();
        check({tag, "_hold_vld"}, MW'(rsp_valid), MW'(1));
        check({tag, "_hold_msg"}, rsp_msg, j_msg);
      end
      rsp_ready = 1'b1;
      step();
      check({tag, "_vld_drop"}, MW'(rsp_valid), MW'(0));
    end
  endtask

  task automatic expect_job(input string tag, input int lat, input int inv, input int ex,
                            input bit id, input bit err, input logic [MW-1:0] msg);
    check({tag, "_lat"},     MW'(j_lat), MW'(lat));
    check({tag, "_inv_cnt"}, MW'(j_inv), MW'(inv));
    check({tag, "_exp_cnt"}, MW'(j_exp), MW'(ex));
    check({tag, "_id"},      MW'(j_id),  MW'(id));
    check({tag, "_err"},     MW'(j_err), MW'(err));
    check({tag, "_msg"},     j_msg, msg);
  endtask

  // Both requesters valid together with P2/Q2 (cached): expect grant 0 then 1, the second one
  // in the cycle right after the first response is consumed.
  task automatic run_pair(input logic [MW-1:0] m0, input logic [MW-1:0] m1, input string tag);
    bit got, g;
    int w, lat;
    step();
    req0_p = P2; req0_q = Q2; req0_dir = 1'b0; req0_msg = m0;
    req1_p = P2; req1_q = Q2; req1_dir = 1'b0; req1_msg = m1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      got = 1'b0;
      w = 0;
      for (int i = 0; i < 20; i++) begin
        if (req0_ready || req1_ready) begin got = 1'b1; break; end
        step();
        w++;
      end
      check({tag, "_grant"}, MW'(got), MW'(1));
      check({tag, "_one_hot"}, MW'(req0_ready & req1_ready), MW'(0));
      g = req1_ready;
      check({tag, "_order"}, MW'(g), MW'(k[0]));
      if (k == 1) check({tag, "_b2b"}, MW'(w), MW'(0));
      step();
      if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
      lat = -1;
      for (int c = 1; c < 40; c++) begin
        if (rsp_valid) begin lat = c; break; end
        step();
      end
      check({tag, "_lat"}, MW'(lat), MW'(6));
      check({tag, "_id"},  MW'(rsp_id), MW'(g));
      check({tag, "_msg"}, rsp_msg, (g ? m1 : m0) ^ KEY);
      step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, MW'({rsp_valid, rsp_err, rsp_id, core_dir, core_reset_inverter,
                              core_reset_mod_exp, req0_ready, req1_ready}), MW'(0));
    check({tag, "_core_p"},  MW'(core_p), MW'(0));
    check({tag, "_core_msg"}, core_msg, MW'(0));
    check({tag, "_rsp_msg"}, rsp_msg, MW'(0));
  endtask

  initial begin
    bit seen;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_p = '0; req0_q = '0; req1_p = '0; req1_q = '0;
    req0_dir = 1'b0; req1_dir = 1'b0; req0_msg = '0; req1_msg = '0;

    // Reset state, with a request pending that must not be acknowledged.
    step(); step();
    req0_valid = 1'b1;
    #1;
    check_all_zero("reset");
    req0_valid = 1'b0;
    step();
    rst_n = 1'b1;

    // Single job (inverter 3 WAIT cycles, mod-exp 4 WAIT cycles): grant c0, INV_GO c1,
    // INV_WAIT c2-c4, EXP_GO c5, EXP_WAIT c6-c9, rsp_valid c10. Response held 3 cycles.
    run_job(1'b0, P1, Q1, 1'b0, M1, 3, "job1");
    expect_job("job1", 10, 1, 1, 1'b0, 1'b0, M1 ^ KEY);
    check("job1_core_p",   MW'(core_p), MW'(P1));
    check("job1_core_q",   MW'(core_q), MW'(Q1));
    check("job1_core_msg", core_msg, M1);

    // Cache hit decrypt from req1: grant c0, EXP_GO c1, EXP_WAIT c2-c5, rsp_valid c6.
    run_job(1'b1, P1, Q1, 1'b1, M1 ^ KEY, 0, "hit");
    expect_job("hit", 6, 0, 1, 1'b1, 1'b0, M1);
    check("hit_core_dir", MW'(core_dir), MW'(1));

    // Stale inverter finish: pulse c1, first INV_WAIT cycle c2 ignored, EXP_GO c4, rsp c9.
    inv_force = 1'b1;
    run_job(1'b0, P2, Q2, 1'b0, M2, 0, "stale");
    inv_force = 1'b0;
    expect_job("stale", 9, 1, 1, 1'b0, 1'b0, M2 ^ KEY);
    check("stale_gap", MW'(j_exp_at - j_inv_at), MW'(3));

    // Timeout on a cache hit: EXP_WAIT c2-c17 (16 cycles), rsp_valid c18 with err=1, msg=0.
    exp_stuck = 1'b1;
    run_job(1'b1, P2, Q2, 1'b1, M3, 0, "tmo");
    exp_stuck = 1'b0;
    expect_job("tmo", 18, 0, 1, 1'b1, 1'b1, MW'(0));

    // Same key after the timeout: cache was dropped, so the inverter runs again.
    run_job(1'b1, P2, Q2, 1'b0, M3, 0, "rerun");
    expect_job("rerun", 10, 1, 1, 1'b1, 1'b0, M3 ^ KEY);

    // Contention twice: grants 0,1,0,1.
    run_pair(M4, M5, "pairA");
    run_pair(M5, M4, "pairB");

    // Reset while req0's job sits in EXP_WAIT with rsp_ready high.
    step();
    req0_p = P3; req0_q = Q3; req0_dir = 1'b0; req0_msg = M1; req0_valid = 1'b1;
    rsp_ready = 1'b1; exp_stuck = 1'b1;
    #1;
    check("rstjob_grant", MW'(req0_ready), MW'(1));
    step();
    req0_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (core_reset_mod_exp) begin seen = 1'b1; break; end
      step();
    end
    check("rstjob_exp_go", MW'(seen), MW'(1));
    step(); step();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_all_zero("midrst");
    step();
    rst_n = 1'b1;
    exp_stuck = 1'b0;
    #1;
    check("midrst_no_rsp", MW'(rsp_valid), MW'(0));
    check("midrst_prio0",  MW'({req1_ready, req0_ready}), MW'(2'b01));
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Cache was cleared by reset: the same key runs the inverter again.
    run_job(1'b0, P3, Q3, 1'b0, M2, 0, "post");
    expect_job("post", 10, 1, 1, 1'b0, 1'b0, M2 ^ KEY);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
